// File: rtl/poly_ctrl_pkg.sv
// Shared encodings and sequencing limits for the polynomial-op controller.
package poly_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NTT    = 2'd0,
    OP_INTT   = 2'd1,
    OP_MULT   = 2'd2,
    OP_ADDSUB = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int         NTT_STAGES    = 7;
  localparam int         BEATS         = 32;
  localparam logic [7:0] NTT_LAST      = 8'(NTT_STAGES * BEATS - 1);
  localparam logic [7:0] MULT_LAST     = 8'd139;
  localparam logic [7:0] MULT_RD_LAST  = 8'd127;
  localparam logic [7:0] MULT_WR_FIRST = 8'd12;
  localparam logic [7:0] AS_LAST       = 8'd67;
  localparam logic [7:0] AS_RD_LAST    = 8'd63;
  localparam logic [7:0] AS_WR_FIRST   = 8'd4;

  function automatic logic is_ntt(input op_e o);
    return (o == OP_NTT) || (o == OP_INTT);
  endfunction

endpackage

// File: rtl/valid_pipe.sv
// Fixed-depth valid delay line: o_vld is i_vld delayed by PIPE_LAT cycles.
module valid_pipe #(
  parameter int PIPE_LAT = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  output logic o_vld
);

  logic [PIPE_LAT:1] r_vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      for (int k = 2; k <= PIPE_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
    end
  end

  assign o_vld = r_vld_pipe[PIPE_LAT];

endmodule

// File: rtl/poly_op_ctrl.sv
// Sequencer for NTT/INTT/MULT/ADDSUB: drives counter, mode and read/write strobes
// to the address generator; NTT stages are separated by butterfly-pipeline drains.
module poly_op_ctrl
  import poly_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic       rd_en,
  output logic       wr_en
);

  localparam logic [2:0] LAT_M1 = 3'(PIPE_LAT - 1);

  state_e     r_state;
  op_e        r_mode;
  logic [7:0] r_cnt;
  logic [2:0] r_dcnt;
  logic       r_busy, r_done, r_rd, r_wr;

  logic [7:0] w_cnt_inc, w_last, w_rd_last, w_wr_first;
  logic       w_ntt, w_pipe_wr;

  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_ntt      = is_ntt(r_mode);
  assign w_last     = (r_mode == OP_MULT) ? MULT_LAST     : AS_LAST;
  assign w_rd_last  = (r_mode == OP_MULT) ? MULT_RD_LAST  : AS_RD_LAST;
  assign w_wr_first = (r_mode == OP_MULT) ? MULT_WR_FIRST : AS_WR_FIRST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= OP_NTT;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_mode  <= op_e'(op);
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_ntt) begin
            if (r_cnt == NTT_LAST) begin
              r_state <= S_FLUSH;
              r_rd    <= 1'b0;
              r_dcnt  <= '0;
            end else if (&r_cnt[4:0]) begin
              r_state <= S_DRAIN;
              r_rd    <= 1'b0;
              r_dcnt  <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (r_cnt == w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
          end else begin
            // MULT/ADDSUB have a fixed write offset, so strobes come straight from the count
            r_cnt <= w_cnt_inc;
            r_rd  <= (w_cnt_inc <= w_rd_last);
            r_wr  <= (w_cnt_inc >= w_wr_first);
          end
        end
        S_DRAIN: begin
          if (r_dcnt == LAT_M1) begin
            r_state <= S_RUN;
            r_cnt   <= w_cnt_inc;
            r_rd    <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        S_FLUSH: begin
          if (r_dcnt == LAT_M1) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Only NTT reads enter the delay line, so it is empty whenever another op starts.
  valid_pipe #(.PIPE_LAT(PIPE_LAT)) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (r_rd & w_ntt),
    .o_vld (w_pipe_wr)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign mode        = r_mode;
  assign clk_counter = r_cnt;
  assign rd_en       = r_rd;
  assign wr_en       = w_ntt ? w_pipe_wr : r_wr;

endmodule

// File: tb/tb_poly_op_ctrl.sv
// Bench for poly_op_ctrl: per-op expectations queued at start, checked at done.
module tb_poly_op_ctrl;

  localparam int PL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic       busy, done, rd_en, wr_en;
  logic [1:0] mode;
  logic [7:0] clk_counter;

  logic       b1, d1, r1, w1, b7, d7, r7, w7;
  logic [1:0] m1, m7;
  logic [7:0] c1, c7;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poly_op_ctrl #(.PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .busy(busy), .done(done),
    .mode(mode), .clk_counter(clk_counter), .rd_en(rd_en), .wr_en(wr_en));

  poly_op_ctrl #(.PIPE_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .busy(b1), .done(d1),
    .mode(m1), .clk_counter(c1), .rd_en(r1), .wr_en(w1));

  poly_op_ctrl #(.PIPE_LAT(7)) u_l7 (
    .clk(clk), .rst(rst), .start(start), .op(op), .busy(b7), .done(d7),
    .mode(m7), .clk_counter(c7), .rd_en(r7), .wr_en(w7));

  typedef struct {
    int op; int busy; int rd; int wr; int wfirst; int maxc; int hold; int dly;
  } exp_t;

  exp_t sb_q[$];
  int   rdq[$];

  task automatic push_exp(input int o);
    exp_t e;
    e.op = o;
    if (o < 2) begin
      e.busy = 224 + 7 * PL; e.rd = 224; e.wr = 224; e.wfirst = PL;
      e.maxc = 223; e.hold = PL; e.dly = PL;
    end else if (o == 2) begin
      e.busy = 140; e.rd = 128; e.wr = 128; e.wfirst = 12;
      e.maxc = 139; e.hold = 0; e.dly = 12;
    end else begin
      e.busy = 68; e.rd = 64; e.wr = 64; e.wfirst = 4;
      e.maxc = 67; e.hold = 0; e.dly = 4;
    end
    sb_q.push_back(e);
  endtask

  // Transaction monitor for the main instance
  int cyc = 0, m_busy = 0, m_rd = 0, m_wr = 0, m_wfirst = -1, m_max = 0;
  int m_hold = 0, m_dly = 0, m_jump = 0, m_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    int   t, xd;
    if (rst) begin
      m_busy = 0; m_rd = 0; m_wr = 0; m_wfirst = -1; m_max = 0;
      m_hold = 0; m_dly = 0; m_jump = 0; m_prev = 0;
      rdq.delete();
    end else begin
      cyc++;
      xd = (sb_q.size() > 0) ? sb_q[0].dly : 0;
      if (busy) begin
        m_busy++;
        if (m_busy == 1) begin
          if (clk_counter != 8'd0) m_jump++;
        end else if (int'(clk_counter) != m_prev && int'(clk_counter) != m_prev + 1) m_jump++;
        if (int'(clk_counter) > m_max) m_max = int'(clk_counter);
        if (!rd_en && clk_counter == 8'd31) m_hold++;
      end
      if (rd_en) begin m_rd++; rdq.push_back(cyc); end
      if (wr_en) begin
        m_wr++;
        if (m_wr == 1) m_wfirst = int'(clk_counter);
        if (rdq.size() == 0) m_dly++;
        else begin t = rdq.pop_front(); if (cyc - t != xd) m_dly++; end
      end
      m_prev = int'(clk_counter);
      if (done) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_underflow: done with no queued op (got 1 done, want 0)");
          n_fail++;
        end else begin
          e = sb_q.pop_front();
          n_tests += 9;
          if (m_busy !== e.busy) begin $display("FAIL op%0d busy_cycles: got %0d want %0d", e.op, m_busy, e.busy); n_fail++; end
          if (m_rd !== e.rd) begin $display("FAIL op%0d rd_beats: got %0d want %0d", e.op, m_rd, e.rd); n_fail++; end
          if (m_wr !== e.wr) begin $display("FAIL op%0d wr_beats: got %0d want %0d", e.op, m_wr, e.wr); n_fail++; end
          if (m_wfirst !== e.wfirst) begin $display("FAIL op%0d wr_first_cnt: got %0d want %0d", e.op, m_wfirst, e.wfirst); n_fail++; end
          if (m_max !== e.maxc) begin $display("FAIL op%0d max_cnt: got %0d want %0d", e.op, m_max, e.maxc); n_fail++; end
          if (m_hold !== e.hold) begin $display("FAIL op%0d hold31: got %0d want %0d", e.op, m_hold, e.hold); n_fail++; end
          if (m_dly !== 0 || rdq.size() != 0) begin $display("FAIL op%0d wr_delay: got %0d errs %0d left want 0 0", e.op, m_dly, rdq.size()); n_fail++; end
          if (m_jump !== 0) begin $display("FAIL op%0d cnt_contig: got %0d jumps want 0", e.op, m_jump); n_fail++; end
          if (int'(mode) !== e.op) begin $display("FAIL op%0d mode_at_done: got %0d want %0d", e.op, mode, e.op); n_fail++; end
        end
        m_busy = 0; m_rd = 0; m_wr = 0; m_wfirst = -1; m_max = 0;
        m_hold = 0; m_dly = 0; m_jump = 0;
        rdq.delete();
      end
    end
  end

  // Per-operation busy/write totals of the PIPE_LAT=1 and PIPE_LAT=7 instances
  int a1_b = 0, a1_w = 0, a7_b = 0, a7_w = 0;
  int l1_busy = 0, l1_wr = 0, l7_busy = 0, l7_wr = 0;
  bit l1_seen = 0, l7_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      a1_b = 0; a1_w = 0; a7_b = 0; a7_w = 0;
    end else begin
      if (b1) a1_b++;
      if (w1) a1_w++;
      if (b7) a7_b++;
      if (w7) a7_w++;
      if (d1) begin l1_busy = a1_b; l1_wr = a1_w; l1_seen = 1; a1_b = 0; a1_w = 0; end
      if (d7) begin l7_busy = a7_b; l7_wr = a7_w; l7_seen = 1; a7_b = 0; a7_w = 0; end
    end
  end

  task automatic pulse_start(input logic [1:0] o);
    start = 1'b1; op = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_main_done(input string nm);
    int i;
    for (i = 0; i < 1000 && !done; i++) @(negedge clk);
    n_tests++;
    if (!done) begin $display("FAIL %s timeout: done not seen in %0d cycles", nm, i); n_fail++; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, mode, clk_counter, rd_en, wr_en} !== 14'd0) begin
      $display("FAIL reset_outputs: got %h want 0", {busy, done, mode, clk_counter, rd_en, wr_en}); n_fail++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, clk_counter, rd_en, wr_en} !== 12'd0) begin
      $display("FAIL idle_outputs: got %h want 0", {busy, done, clk_counter, rd_en, wr_en}); n_fail++;
    end
  endtask

  task automatic test_ntt;
    int i;
    l1_seen = 0; l7_seen = 0;
    push_exp(0);
    pulse_start(2'd0);
    n_tests++;
    if (busy !== 1'b1 || clk_counter !== 8'd0 || rd_en !== 1'b1) begin
      $display("FAIL ntt_first_beat: got busy=%b cnt=%0d rd=%b want 1 0 1", busy, clk_counter, rd_en); n_fail++;
    end
    wait_main_done("ntt");
    for (i = 0; i < 50 && !(l1_seen && l7_seen); i++) @(negedge clk);
    n_tests += 4;
    if (l1_busy !== 231) begin $display("FAIL lat1_busy: got %0d want 231", l1_busy); n_fail++; end
    if (l1_wr !== 224) begin $display("FAIL lat1_wr: got %0d want 224", l1_wr); n_fail++; end
    if (l7_busy !== 273) begin $display("FAIL lat7_busy: got %0d want 273", l7_busy); n_fail++; end
    if (l7_wr !== 224) begin $display("FAIL lat7_wr: got %0d want 224", l7_wr); n_fail++; end
  endtask

  task automatic test_mult;
    push_exp(2);
    pulse_start(2'd2);
    wait_main_done("mult");
    @(negedge clk);
    n_tests++;
    if ({busy, done, clk_counter, rd_en, wr_en} !== 12'd0 || mode !== 2'd2) begin
      $display("FAIL mult_idle: got %h mode=%0d want 0 mode=2", {busy, done, clk_counter, rd_en, wr_en}, mode); n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    push_exp(3);
    push_exp(3);
    pulse_start(2'd3);
    wait_main_done("addsub1");
    start = 1'b1; op = 2'd3;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || clk_counter !== 8'd0 || rd_en !== 1'b1) begin
      $display("FAIL b2b_restart: got busy=%b done=%b cnt=%0d rd=%b want 1 0 0 1", busy, done, clk_counter, rd_en); n_fail++;
    end
    wait_main_done("addsub2");
  endtask

  task automatic test_ignore_start;
    int i;
    push_exp(1);
    pulse_start(2'd1);
    for (i = 0; i < 400 && clk_counter != 8'd100; i++) @(negedge clk);
    n_tests++;
    if (clk_counter !== 8'd100) begin $display("FAIL intt_reach100: got %0d want 100", clk_counter); n_fail++; end
    pulse_start(2'd2);
    n_tests++;
    if (mode !== 2'd1 || busy !== 1'b1) begin
      $display("FAIL intt_ignore: got mode=%0d busy=%b want 1 1", mode, busy); n_fail++;
    end
    wait_main_done("intt");
  endtask

  task automatic test_reset_drain;
    int i;
    pulse_start(2'd0);
    for (i = 0; i < 100 && !(busy && !rd_en && clk_counter == 8'd31); i++) @(negedge clk);
    n_tests++;
    if (!(busy && !rd_en && clk_counter == 8'd31)) begin
      $display("FAIL drain_reach: got cnt=%0d rd=%b want 31 0", clk_counter, rd_en); n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, mode, clk_counter, rd_en, wr_en} !== 14'd0) begin
      $display("FAIL async_reset: got %h want 0", {busy, done, mode, clk_counter, rd_en, wr_en}); n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_exp(2);
    pulse_start(2'd2);
    wait_main_done("mult_after_rst");
  endtask

  initial begin
    test_reset();
    test_ntt();
    test_mult();
    test_back_to_back();
    test_ignore_start();
    test_reset_drain();
    repeat (10) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin $display("FAIL sb_leftover: got %0d want 0", sb_q.size()); n_fail++; end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
